// File: rtl/reg_prog_pkg.sv
// rtl/reg_prog_pkg.sv - shared states, error codes and limits for the write-once register programmer
package reg_prog_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRECHK,
        ST_WRITE,
        ST_SETTLE,
        ST_VERIFY,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_LOCKED  = 2'b01;
    localparam logic [1:0] ERR_VERIFY  = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    localparam int TIMEOUT_LIMIT = 1024;

endpackage

// File: rtl/reg_prog_settle_timer.sv
// rtl/reg_prog_settle_timer.sv - loadable down-counter that stops at zero
module reg_prog_settle_timer #(
    parameter int W = 16
) (
    input  logic         Clk,
    input  logic         ip_resetn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         zero
);

    always_ff @(posedge Clk or negedge ip_resetn) begin
        if (!ip_resetn) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/register_write_once_programmer.sv
// rtl/register_write_once_programmer.sv - programs and verifies a write-once register; REG_PROG_TIMEOUT_EN adds a busy watchdog
module register_write_once_programmer
    import reg_prog_pkg::*;
#(
    parameter int DATA_W        = 16,
    parameter int SETTLE_CYCLES = 2,
    parameter int MAX_RETRIES   = 3
) (
    input  logic              Clk,
    input  logic              ip_resetn,
    input  logic              start,
    input  logic [DATA_W-1:0] cfg_value,
    input  logic [DATA_W-1:0] reg_data_out,
    output logic              reg_write,
    output logic [DATA_W-1:0] reg_data_in,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [3:0]        retry_cnt,
    output logic [DATA_W-1:0] readback
);

    localparam int TMR_W = 16;

    state_t             state;
    logic [TMR_W-1:0]   settle_count;
    logic               settle_zero;
    logic               timeout_hit;

    // Loaded during the write cycle so SETTLE lasts exactly SETTLE_CYCLES cycles.
    reg_prog_settle_timer #(.W(TMR_W)) u_settle (
        .Clk       (Clk),
        .ip_resetn (ip_resetn),
        .load      (state == ST_WRITE),
        .load_val  (TMR_W'(SETTLE_CYCLES - 1)),
        .en        (state == ST_SETTLE),
        .count     (settle_count),
        .zero      (settle_zero)
    );

`ifdef REG_PROG_TIMEOUT_EN
    logic [TMR_W-1:0] wd_count;
    logic             wd_zero;

    // Reaches zero in the 1024th busy cycle, so ERR is entered right after it.
    reg_prog_settle_timer #(.W(TMR_W)) u_watchdog (
        .Clk       (Clk),
        .ip_resetn (ip_resetn),
        .load      ((state == ST_IDLE) && start),
        .load_val  (TMR_W'(TIMEOUT_LIMIT - 1)),
        .en        (busy),
        .count     (wd_count),
        .zero      (wd_zero)
    );

    assign timeout_hit = busy && wd_zero;
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge Clk or negedge ip_resetn) begin
        if (!ip_resetn) begin
            state       <= ST_IDLE;
            reg_write   <= 1'b0;
            reg_data_in <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            err_code    <= ERR_NONE;
            retry_cnt   <= '0;
            readback    <= '0;
        end else begin
            reg_write <= 1'b0;
            done      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        reg_data_in <= cfg_value;
                        error       <= 1'b0;
                        err_code    <= ERR_NONE;
                        retry_cnt   <= '0;
                        busy        <= 1'b1;
                        state       <= ST_PRECHK;
                    end
                end
                ST_PRECHK: begin
                    readback <= reg_data_out;
                    if (reg_data_out[0]) begin
                        error    <= 1'b1;
                        err_code <= ERR_LOCKED;
                        busy     <= 1'b0;
                        state    <= ST_ERR;
                    end else begin
                        reg_write <= 1'b1;
                        state     <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    state <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_zero) begin
                        state <= ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    readback <= reg_data_out;
                    // A latched lock bit reads back as written, so the expected word is cfg itself.
                    if (reg_data_out == reg_data_in) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_DONE;
                    end else if (retry_cnt < 4'(MAX_RETRIES)) begin
                        retry_cnt <= retry_cnt + 1'b1;
                        reg_write <= 1'b1;
                        state     <= ST_WRITE;
                    end else begin
                        error    <= 1'b1;
                        err_code <= ERR_VERIFY;
                        busy     <= 1'b0;
                        state    <= ST_ERR;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                ST_ERR:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
            if (timeout_hit) begin
                reg_write <= 1'b0;
                done      <= 1'b0;
                error     <= 1'b1;
                err_code  <= ERR_TIMEOUT;
                busy      <= 1'b0;
                state     <= ST_ERR;
            end
        end
    end

endmodule

// File: tb/tb_register_write_once_programmer.sv
// tb/tb_register_write_once_programmer.sv - scoreboard bench for the write-once register programmer
module tb_register_write_once_programmer;

    logic        Clk = 1'b0;
    logic        ip_resetn = 1'b0;
    logic        start = 1'b0;
    logic [15:0] cfg_value = '0;
    logic [15:0] reg_data_out;
    logic        reg_write;
    logic [15:0] reg_data_in;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  err_code;
    logic [3:0]  retry_cnt;
    logic [15:0] readback;

    typedef struct {
        logic [7:0]  st;      // {done, error, err_code, retry_cnt}
        logic [15:0] rb;
        int          writes;
        int          lat;
        bit          bad;     // back-to-back writes, wrong write data, or write at exit
    } res_t;

    res_t sb[$];
    int   n_pass = 0;
    int   n_checks = 0;

    logic [15:0] tgt_q = '0;
    int          tgt_ign = 0;
    logic        tgt_load = 1'b0;
    logic [15:0] tgt_init = '0;
    int          tgt_ign_init = 0;
    logic        tgt_stuck = 1'b0;

    always #5 Clk = ~Clk;

    register_write_once_programmer dut (
        .Clk          (Clk),
        .ip_resetn    (ip_resetn),
        .start        (start),
        .cfg_value    (cfg_value),
        .reg_data_out (reg_data_out),
        .reg_write    (reg_write),
        .reg_data_in  (reg_data_in),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .err_code     (err_code),
        .retry_cnt    (retry_cnt),
        .readback     (readback)
    );

    // Write-once target: bit 0 locks it; can ignore the first N writes or be stuck.
    always @(posedge Clk) begin
        if (tgt_load) begin
            tgt_q   <= tgt_init;
            tgt_ign <= tgt_ign_init;
        end else if (reg_write) begin
            if (tgt_ign > 0) tgt_ign <= tgt_ign - 1;
            else if (!tgt_stuck && !tgt_q[0]) tgt_q <= reg_data_in;
        end
    end
    assign reg_data_out = tgt_q;

    task automatic tgt_setup(input logic [15:0] init, input int ign, input logic stuck);
        tgt_init = init; tgt_ign_init = ign; tgt_stuck = stuck; tgt_load = 1'b1;
        @(posedge Clk); #1;
        tgt_load = 1'b0;
    endtask

    task automatic run_op(input logic [15:0] cfg, input int glitch, input int budget, output res_t o);
        int   cyc;
        bit   seen;
        logic prev_w;
        o = '{st: '0, rb: '0, writes: 0, lat: 0, bad: 0};
        cyc = 0; seen = 0; prev_w = 1'b0;
        cfg_value = cfg; start = 1'b1;
        while (!seen && cyc < budget) begin
            @(posedge Clk); #1;
            cyc++;
            if (cyc == 1) start = 1'b0;
            if (reg_write) begin
                o.writes++;
                if (prev_w) o.bad = 1;
                if (reg_data_in !== cfg) o.bad = 1;
            end
            prev_w = reg_write;
            if (done || error) begin
                seen  = 1;
                o.st  = {done, error, err_code, retry_cnt};
                o.rb  = readback;
                o.lat = cyc;
                if (reg_write || reg_data_in !== cfg) o.bad = 1;
            end
            if (cyc == glitch) begin
                start = 1'b1; cfg_value = ~cfg;
            end else if (glitch != 0 && cyc == glitch + 1) begin
                start = 1'b0; cfg_value = cfg;
            end
        end
        if (!seen) o.lat = -1;
    endtask

    task automatic test_reset();
        ip_resetn = 1'b0;
        @(posedge Clk); #1;
        if ({reg_write, busy, done, error, err_code, retry_cnt, readback, reg_data_in} !== 42'd0)
            $display("FAIL reset_outputs got %h want 0", {reg_write, busy, done, error, err_code, retry_cnt, readback, reg_data_in});
        else n_pass++;
        n_checks++;
        ip_resetn = 1'b1;
        @(posedge Clk); #1;
    endtask

    task automatic test_op(input string name, input logic [15:0] cfg, input int glitch, input int budget);
        res_t o, e;
        run_op(cfg, glitch, budget, o);
        if (sb.size() == 0) begin
            $display("FAIL %s scoreboard empty", name); n_checks++; return;
        end
        e = sb.pop_front();
        if (o.lat != e.lat) $display("FAIL %s latency got %0d want %0d", name, o.lat, e.lat);
        else n_pass++;
        n_checks++;
        if (o.st !== e.st) $display("FAIL %s status{done,error,code,retry} got %h want %h", name, o.st, e.st);
        else n_pass++;
        n_checks++;
        if (o.rb !== e.rb) $display("FAIL %s readback got %h want %h", name, o.rb, e.rb);
        else n_pass++;
        n_checks++;
        if (o.writes != e.writes) $display("FAIL %s write_pulses got %0d want %0d", name, o.writes, e.writes);
        else n_pass++;
        n_checks++;
        if (o.bad != e.bad) $display("FAIL %s write_integrity got %0d want %0d", name, o.bad, e.bad);
        else n_pass++;
        n_checks++;
    endtask

    task automatic test_clean();
        tgt_setup(16'h0000, 0, 1'b0);
        sb.push_back('{st: {1'b1, 1'b0, 2'b00, 4'd0}, rb: 16'hA5A5, writes: 1, lat: 6, bad: 0});
        test_op("clean", 16'hA5A5, 0, 100);
    endtask

    task automatic test_locked();
        tgt_setup(16'h0011, 0, 1'b0);
        sb.push_back('{st: {1'b0, 1'b1, 2'b01, 4'd0}, rb: 16'h0011, writes: 0, lat: 2, bad: 0});
        test_op("locked", 16'h1234, 0, 100);
        @(posedge Clk); #1;
        if ({error, err_code} !== 3'b101) $display("FAIL locked_sticky got %b want 101", {error, err_code});
        else n_pass++;
        n_checks++;
    endtask

    task automatic test_retry();
        tgt_setup(16'h0000, 2, 1'b0);
        sb.push_back('{st: {1'b1, 1'b0, 2'b00, 4'd2}, rb: 16'h00F1, writes: 3, lat: 14, bad: 0});
        test_op("retry", 16'h00F1, 0, 100);
    endtask

    task automatic test_stuck();
        tgt_setup(16'h0000, 0, 1'b1);
        sb.push_back('{st: {1'b0, 1'b1, 2'b10, 4'd3}, rb: 16'h0000, writes: 4, lat: 18, bad: 0});
        test_op("stuck", 16'h8001, 0, 100);
    endtask

    task automatic test_back_to_back();
        tgt_setup(16'h0000, 0, 1'b0);
        sb.push_back('{st: {1'b1, 1'b0, 2'b00, 4'd0}, rb: 16'h3C3C, writes: 1, lat: 6, bad: 0});
        test_op("start_while_busy", 16'h3C3C, 3, 100);
        tgt_setup(16'h0000, 0, 1'b0);
        sb.push_back('{st: {1'b1, 1'b0, 2'b00, 4'd0}, rb: 16'h4242, writes: 1, lat: 6, bad: 0});
        test_op("start_at_exit", 16'h4242, 6, 100);
        @(posedge Clk); #1;
        start = 1'b0; cfg_value = 16'h4242;
        if (busy !== 1'b0) $display("FAIL exit_start_idle got %b want 0", busy);
        else n_pass++;
        n_checks++;
        @(posedge Clk); #1;
        if ({busy, reg_data_in} !== {1'b0, 16'h4242}) $display("FAIL exit_start_ignored got %h want %h", {busy, reg_data_in}, {1'b0, 16'h4242});
        else n_pass++;
        n_checks++;
    endtask

    task automatic test_reset_midop();
        tgt_setup(16'h0000, 0, 1'b0);
        cfg_value = 16'h0040; start = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(posedge Clk); #1;
            start = 1'b0;
        end
        ip_resetn = 1'b0;
        #2;
        if ({reg_write, busy, done, error, err_code, retry_cnt, readback, reg_data_in} !== 42'd0)
            $display("FAIL midop_reset_async got %h want 0", {reg_write, busy, done, error, err_code, retry_cnt, readback, reg_data_in});
        else n_pass++;
        n_checks++;
        @(posedge Clk); #1;
        if ({reg_write, busy, done, error, err_code, retry_cnt, readback, reg_data_in} !== 42'd0)
            $display("FAIL midop_reset_hold got %h want 0", {reg_write, busy, done, error, err_code, retry_cnt, readback, reg_data_in});
        else n_pass++;
        n_checks++;
        ip_resetn = 1'b1;
        @(posedge Clk); #1;
        if (done !== 1'b0) $display("FAIL midop_no_done got %b want 0", done);
        else n_pass++;
        n_checks++;
        sb.push_back('{st: {1'b1, 1'b0, 2'b00, 4'd0}, rb: 16'h0002, writes: 1, lat: 6, bad: 0});
        test_op("after_reset", 16'h0002, 0, 100);
    endtask

`ifdef REG_PROG_TIMEOUT_EN
    task automatic test_timeout();
        tgt_setup(16'h0000, 0, 1'b0);
        force dut.settle_zero = 1'b0;
        sb.push_back('{st: {1'b0, 1'b1, 2'b11, 4'd0}, rb: 16'h0000, writes: 1, lat: 1025, bad: 0});
        test_op("timeout", 16'h0100, 0, 1200);
        release dut.settle_zero;
        @(posedge Clk); #1;
        if ({reg_write, error, err_code} !== 4'b0111) $display("FAIL timeout_after got %b want 0111", {reg_write, error, err_code});
        else n_pass++;
        n_checks++;
    endtask
`endif

    initial begin
        test_reset();
        test_clean();
        test_locked();
        test_retry();
        test_stuck();
        test_back_to_back();
        test_reset_midop();
`ifdef REG_PROG_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
